tile_probe_reader: RTL
======================

Name: tile_probe_reader

Overview:
- Read-side counterpart of the snake draw FSM. The draw FSM writes 10x10 tiles into the 160x120 3-bit frame buffer through x/y/colour/plot; this block reads a tile back out of the same buffer.
- On request, it scans one XDIM x YDIM tile at (x0,y0) through the frame buffer's synchronous read port.
- It counts pixels equal to a target colour and flags any non-background pixel.
- The game controller uses it before each head move to detect apple pickup (target = apple colour), self-collision (nonbg) and wall collision (out of bounds).

Parameters:
- XDIM, 10, tile width in pixels
- YDIM, 10, tile height in pixels
- XSCREEN, 160, screen width
- YSCREEN, 120, screen height
- BG_COLOUR, 3'b000, background colour, never counted as occupied

Ports:
- Clock  in  1  system clock (CLOCK_50 at top level)
- Reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- x0  in  8  tile left column; sampled with start
- y0  in  7  tile top row; sampled with start
- target  in  3  colour to count; sampled with start
- mem_x  out  8  frame buffer read column
- mem_y  out  7  frame buffer read row
- mem_rd  out  1  read strobe; data returns exactly 1 cycle later
- mem_colour  in  3  read data for the address strobed in the previous cycle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; results valid from this cycle
- count  out  7  pixels == target (XDIM*YDIM <= 127 required)
- hit  out  1  count != 0
- nonbg  out  1  at least one pixel != BG_COLOUR
- oob  out  1  tile extends past the screen

Behaviour:
- Reset (async, active-high): state = IDLE. busy, done, mem_rd, count, hit, nonbg, oob = 0. mem_x, mem_y = 0. Internal XC/YC counters = 0.
- States: IDLE, CHECK, READ, DRAIN, DONE.
- IDLE: start=1 latches x0, y0, target; clears count, hit, nonbg, oob; next state CHECK. start=0 stays in IDLE. Previous results hold until the next accepted start.
- CHECK (busy=1): bounds test uses 9-bit arithmetic and no wrap.
  - If x0+XDIM > XSCREEN or y0+YDIM > YSCREEN: oob=1, no reads, next state DONE.
  - Otherwise XC=YC=0, next state READ.
- READ (busy=1, mem_rd=1):
  - mem_x = x0+XC and mem_y = y0+YC, driven combinationally from registers.
  - XC increments each cycle, wrapping to 0 at XDIM-1. On that wrap YC increments.
  - After the (XDIM-1, YDIM-1) address, next state DRAIN.
  - Exactly XDIM*YDIM read cycles, row-major order.
- Data path: a valid flag is mem_rd delayed by one cycle. When the flag is set:
  - count += (mem_colour == target)
  - nonbg |= (mem_colour != BG_COLOUR)
  - hit tracks count != 0, updated in the same cycle
- DRAIN (busy=1, mem_rd=0): captures the final read's data; next state DONE.
- DONE: done=1 and busy=0 for one cycle; next state IDLE. A start during DONE is ignored.
- Latency, start accepted at cycle 0:
  - In-bounds: reads in cycles 2..101, DRAIN in 102, done in 103.
  - oob: done in cycle 2.
- start while busy or in DONE: ignored, no queueing.
- mem_rd is never asserted outside READ. mem_x/mem_y are don't-care when mem_rd=0 but hold their last value.
- Reset mid-scan: immediate return to IDLE with all outputs zeroed. No done pulse is emitted.
- target == BG_COLOUR is legal: count reports background pixels; nonbg is unaffected.

Decomposition:
- Shared package (snake_pkg): XSCREEN, YSCREEN, XDIM, YDIM, BG_COLOUR, the state encoding, and the colour constants (snake, apple, ALT).
- One natural sub-module: the existing UpDn_count, instanced twice as the XC/YC counters (load = clear, enable = step).
- The accumulator and FSM stay in this module.

Test Plan:
- Reset, then zero-filled memory model; start x0=39, y0=59, target=3'b100 -> mem_rd high exactly 100 cycles; done at cycle 103; count=0, hit=0, nonbg=0, oob=0.
- Memory with tile (80,60) filled 3'b100; probe x0=80, y0=60, target=3'b100 -> count=100, hit=1, nonbg=1. Probe x0=75 -> count=50; probe x0=70 -> count=0, nonbg=0.
- Single pixel (49,68)=3'b010, rest background; probe (40,59), target=3'b100 -> count=0, hit=0, nonbg=1. Also check mem_x/mem_y sequence (40,59),(41,59)..(49,68) in row-major order.
- Bounds: x0=150, y0=110 -> in bounds, 100 reads. x0=151 -> oob=1, mem_rd never high, done at cycle 2. y0=111 -> oob=1. x0=255 -> oob=1, no 8-bit wrap.
- Start pulses at cycles 5, 50 and 103 of a scan -> ignored; only one done; results unchanged. A start at cycle 104 (IDLE) is accepted.
- Assert Reset at read cycle 40 -> busy, mem_rd, count drop to 0 asynchronously; no done. Release, then start -> full clean scan with correct count.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants for the snake game datapath: screen/tile geometry,
// colours, the tile probe FSM encoding and the tile bounds test.
package snake_pkg;

    localparam int unsigned XSCREEN = 160;
    localparam int unsigned YSCREEN = 120;
    localparam int unsigned XDIM    = 10;
    localparam int unsigned YDIM    = 10;

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned COL_W = 3;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned CTR_W = 4;
    localparam int unsigned BND_W = 9;

    localparam logic [COL_W-1:0] BG_COLOUR    = 3'b000;
    localparam logic [COL_W-1:0] SNAKE_COLOUR = 3'b010;
    localparam logic [COL_W-1:0] APPLE_COLOUR = 3'b100;
    localparam logic [COL_W-1:0] ALT_COLOUR   = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } probe_state_e;

    // Widened compare so x0 near 255 cannot wrap back on-screen.
    function automatic logic tile_oob(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        logic [BND_W-1:0] x_end;
        logic [BND_W-1:0] y_end;
        x_end = BND_W'(x) + BND_W'(XDIM);
        y_end = BND_W'(y) + BND_W'(YDIM);
        return (x_end > BND_W'(XSCREEN)) || (y_end > BND_W'(YSCREEN));
    endfunction

endpackage

// File: rtl/updn_count.sv
// Loadable up/down counter; load wins over enable.
module updn_count #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = din;
        end else if (en) begin
            cnt_d = up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/tile_probe_reader.sv
// Reads one XDIM x YDIM tile back from the frame buffer, counting pixels of a
// target colour and flagging any non-background pixel or an off-screen tile.
module tile_probe_reader
    import snake_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [COL_W-1:0] target,
    output logic [X_W-1:0]   mem_x,
    output logic [Y_W-1:0]   mem_y,
    output logic             mem_rd,
    input  logic [COL_W-1:0] mem_colour,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             hit,
    output logic             nonbg,
    output logic             oob
);

    probe_state_e     state_q, state_d;
    logic [X_W-1:0]   x0_q, x0_d;
    logic [Y_W-1:0]   y0_q, y0_d;
    logic [COL_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hit_q, hit_d;
    logic             nonbg_q, nonbg_d;
    logic             oob_q, oob_d;
    logic             valid_q, valid_d;

    logic [CTR_W-1:0] xc, yc;
    logic             xc_load, xc_en, yc_load, yc_en;
    logic             x_wrap, last_addr;

    assign x_wrap    = (xc == CTR_W'(XDIM - 1));
    assign last_addr = x_wrap && (yc == CTR_W'(YDIM - 1));

    updn_count #(.WIDTH(CTR_W)) u_xc (
        .clk  (clk),
        .rst  (rst),
        .load (xc_load),
        .en   (xc_en),
        .up   (1'b1),
        .din  ('0),
        .q    (xc)
    );

    updn_count #(.WIDTH(CTR_W)) u_yc (
        .clk  (clk),
        .rst  (rst),
        .load (yc_load),
        .en   (yc_en),
        .up   (1'b1),
        .din  ('0),
        .q    (yc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: state_d = tile_oob(x0_q, y0_q) ? ST_DONE : ST_READ;
            ST_READ:  if (last_addr) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and scan counter control; counters park on the last address
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        mem_rd  = 1'b0;
        xc_load = 1'b0;
        xc_en   = 1'b0;
        yc_load = 1'b0;
        yc_en   = 1'b0;
        unique case (state_q)
            ST_CHECK: begin
                busy    = 1'b1;
                xc_load = 1'b1;
                yc_load = 1'b1;
            end
            ST_READ: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (!last_addr) begin
                    xc_load = x_wrap;
                    xc_en   = !x_wrap;
                    yc_en   = x_wrap;
                end
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign mem_x = x0_q + X_W'(xc);
    assign mem_y = y0_q + Y_W'(yc);

    // Request latch and result accumulator
    always_comb begin
        x0_d     = x0_q;
        y0_d     = y0_q;
        target_d = target_q;
        count_d  = count_q;
        hit_d    = hit_q;
        nonbg_d  = nonbg_q;
        oob_d    = oob_q;
        valid_d  = mem_rd;
        if (state_q == ST_IDLE && start) begin
            x0_d     = x0;
            y0_d     = y0;
            target_d = target;
            count_d  = '0;
            hit_d    = 1'b0;
            nonbg_d  = 1'b0;
            oob_d    = 1'b0;
        end else if (state_q == ST_CHECK && tile_oob(x0_q, y0_q)) begin
            oob_d = 1'b1;
        end
        if (valid_q) begin
            count_d = count_q + CNT_W'(mem_colour == target_q);
            nonbg_d = nonbg_q | (mem_colour != BG_COLOUR);
            hit_d   = (count_d != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q     <= '0;
            y0_q     <= '0;
            target_q <= '0;
            count_q  <= '0;
            hit_q    <= 1'b0;
            nonbg_q  <= 1'b0;
            oob_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            target_q <= target_d;
            count_q  <= count_d;
            hit_q    <= hit_d;
            nonbg_q  <= nonbg_d;
            oob_q    <= oob_d;
            valid_q  <= valid_d;
        end
    end

    assign count = count_q;
    assign hit   = hit_q;
    assign nonbg = nonbg_q;
    assign oob   = oob_q;

endmodule
